signal_edge_detector: RTL and testbench

Detects rising, falling and either-direction transitions on a sampled input bus and reports each in two flavours: a combinational zero-delay pulse valid in the same cycle the new level is seen, and a registered pulse delayed by exactly one clock. It sits between raw control/status inputs and downstream FSMs that need single-cycle edge strobes. Optional input synchronizer stages make it safe for asynchronous inputs.

---
 rtl/signal_edge_detector.sv | 76 +++++++
 tb/tb_signal_edge_detector.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/signal_edge_detector.sv
// Per-bit rising/falling/either edge detector: same-cycle combinational strobes plus
// registered strobes delayed by one clock, behind an optional input synchronizer.
module signal_edge_detector #(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] signal,
    output logic [WIDTH-1:0] zero_delay_rising,
    output logic [WIDTH-1:0] zero_delay_falling,
    output logic [WIDTH-1:0] zero_delay_either,
    output logic [WIDTH-1:0] cycle_delayed_rising,
    output logic [WIDTH-1:0] cycle_delayed_falling,
    output logic [WIDTH-1:0] cycle_delayed_either
);

    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_d;
    logic [WIDTH-1:0] either_d;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] either_q;

    generate
        if (SYNC_STAGES == 0) begin : g_direct
            assign s = signal;
        end else begin : g_sync
            logic [WIDTH-1:0] sync_q [SYNC_STAGES];

            // NOTE: non-blocking assignments let every stage sample its neighbour's old value,
            // so the loop order does not matter and the chain shifts by exactly one stage.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
                end else begin
                    sync_q[0] <= signal;
                    for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
                end
            end

            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    always_comb begin
        rise_d   = s & ~prev_q;
        fall_d   = ~s & prev_q;
        either_d = s ^ prev_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q   <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            either_q <= '0;
        end else begin
            prev_q   <= s;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            either_q <= either_d;
        end
    end

    // With no synchronizer a high input would show as rising during reset; gate it off.
    assign zero_delay_rising     = rise_d & {WIDTH{reset}};
    assign zero_delay_falling    = fall_d & {WIDTH{reset}};
    assign zero_delay_either     = either_d & {WIDTH{reset}};
    assign cycle_delayed_rising  = rise_q;
    assign cycle_delayed_falling = fall_q;
    assign cycle_delayed_either  = either_q;

endmodule

// File: tb/tb_signal_edge_detector.sv
// Bench for signal_edge_detector: a 1-bit direct instance and a 4-bit, 2-stage-synchronized
// instance, checked by directed scenarios and by a history-based model under random input.
module tb_signal_edge_detector;

    logic       clk = 1'b0;
    logic       reset;
    logic       sig1;
    logic [3:0] sig4;

    logic       zr1, zf1, ze1, dr1, df1, de1;
    logic [3:0] zr4, zf4, ze4, dr4, df4, de4;
    logic [5:0]  obs1;
    logic [23:0] obs4;

    int checks   = 0;
    int failures = 0;

    // Levels seen at each rising edge since the last reset; before that everything reads 0.
    logic       hist1[$];
    logic [3:0] hist4[$];

    always #5 clk = ~clk;

    signal_edge_detector #(.WIDTH(1), .SYNC_STAGES(0)) u_dut1 (
        .clk                  (clk),
        .reset                (reset),
        .signal               (sig1),
        .zero_delay_rising    (zr1),
        .zero_delay_falling   (zf1),
        .zero_delay_either    (ze1),
        .cycle_delayed_rising (dr1),
        .cycle_delayed_falling(df1),
        .cycle_delayed_either (de1)
    );

    signal_edge_detector #(.WIDTH(4), .SYNC_STAGES(2)) u_dut4 (
        .clk                  (clk),
        .reset                (reset),
        .signal               (sig4),
        .zero_delay_rising    (zr4),
        .zero_delay_falling   (zf4),
        .zero_delay_either    (ze4),
        .cycle_delayed_rising (dr4),
        .cycle_delayed_falling(df4),
        .cycle_delayed_either (de4)
    );

    assign obs1 = {zr1, zf1, ze1, dr1, df1, de1};
    assign obs4 = {zr4, zf4, ze4, dr4, df4, de4};

    always @(posedge clk) begin
        if (reset) begin
            hist1.push_back(sig1);
            hist4.push_back(sig4);
        end
    end

    always @(negedge reset) begin
        hist1.delete();
        hist4.delete();
    end

    function automatic logic h1(int j);
        if (j < 1 || j > hist1.size()) return 1'b0;
        return hist1[j-1];
    endfunction

    function automatic logic [3:0] h4(int j);
        if (j < 1 || j > hist4.size()) return 4'b0;
        return hist4[j-1];
    endfunction

    // An edge is a difference between the level now visible and the one seen one edge earlier;
    // the delayed flavour is the same comparison one edge further back in history.
    function automatic logic [5:0] model1();
        int   n;
        logic cur, old, dcur, dold;
        if (!reset) return 6'b0;
        n    = hist1.size();
        cur  = sig1;
        old  = h1(n);
        dcur = h1(n);
        dold = h1(n - 1);
        return {cur && !old, !cur && old, cur != old, dcur && !dold, !dcur && dold, dcur != dold};
    endfunction

    // Two synchronizer stages: the visible level is the one sampled one edge ago.
    function automatic logic [23:0] model4();
        int         n;
        logic [3:0] cur, old, dcur, dold;
        logic [3:0] r, f, e, dr, df, de;
        if (!reset) return 24'b0;
        n    = hist4.size();
        cur  = h4(n - 1);
        old  = h4(n - 2);
        dcur = h4(n - 2);
        dold = h4(n - 3);
        for (int b = 0; b < 4; b++) begin
            r[b]  = cur[b] && !old[b];
            f[b]  = !cur[b] && old[b];
            e[b]  = cur[b] != old[b];
            dr[b] = dcur[b] && !dold[b];
            df[b] = !dcur[b] && dold[b];
            de[b] = dcur[b] != dold[b];
        end
        return {r, f, e, dr, df, de};
    endfunction

    task automatic settle(int cycles);
        sig1 = 1'b0;
        sig4 = 4'b0;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        sig1  = 1'b1;
        sig4  = 4'b0;
        #2;
        checks++;
        if (obs1 !== 6'b0) begin
            failures++; $display("FAIL reset_hold_dut1: got %b expected %b", obs1, 6'b0);
        end
        checks++;
        if (obs4 !== 24'b0) begin
            failures++; $display("FAIL reset_hold_dut4: got %h expected %h", obs4, 24'b0);
        end
        #5;
        checks++;
        if (obs1 !== 6'b0) begin
            failures++; $display("FAIL reset_after_edge: got %b expected %b", obs1, 6'b0);
        end
        @(negedge clk);
        reset = 1'b1;
        #2;
        checks++;
        if (obs1 !== 6'b101000) begin
            failures++; $display("FAIL powerup_zero_rise: got %b expected %b", obs1, 6'b101000);
        end
        @(negedge clk); #2;
        checks++;
        if (obs1 !== 6'b000101) begin
            failures++; $display("FAIL powerup_delayed_rise: got %b expected %b", obs1, 6'b000101);
        end
        @(negedge clk); #2;
        checks++;
        if (obs1 !== 6'b0) begin
            failures++; $display("FAIL powerup_level_held: got %b expected %b", obs1, 6'b0);
        end
    endtask

    task automatic test_rising();
        logic [5:0] exp_seq [3] = '{6'b101000, 6'b000101, 6'b000000};
        settle(3);
        sig1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            #2;
            checks++;
            if (obs1 !== exp_seq[k]) begin
                failures++; $display("FAIL rising[%0d]: got %b expected %b", k, obs1, exp_seq[k]);
            end
        end
    endtask

    task automatic test_falling();
        logic [5:0] exp_seq [3] = '{6'b011000, 6'b000011, 6'b000000};
        @(negedge clk);
        sig1 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            #2;
            checks++;
            if (obs1 !== exp_seq[k]) begin
                failures++; $display("FAIL falling[%0d]: got %b expected %b", k, obs1, exp_seq[k]);
            end
        end
    endtask

    task automatic test_alternating();
        logic [5:0] exp_seq [6] = '{6'b101000, 6'b011101, 6'b101011, 6'b011101, 6'b000011, 6'b000000};
        settle(3);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            if (k < 4) sig1 = ~sig1;
            #2;
            checks++;
            if (obs1 !== exp_seq[k]) begin
                failures++; $display("FAIL alternating[%0d]: got %b expected %b", k, obs1, exp_seq[k]);
            end
        end
    endtask

    task automatic test_glitch();
        settle(3);
        sig1 = 1'b1;
        #2;
        checks++;
        if (obs1 !== 6'b101000) begin
            failures++; $display("FAIL glitch_visible: got %b expected %b", obs1, 6'b101000);
        end
        #1 sig1 = 1'b0;
        #1;
        checks++;
        if (obs1 !== 6'b0) begin
            failures++; $display("FAIL glitch_gone: got %b expected %b", obs1, 6'b0);
        end
        @(negedge clk); #2;
        checks++;
        if (obs1 !== 6'b0) begin
            failures++; $display("FAIL glitch_not_delayed: got %b expected %b", obs1, 6'b0);
        end
    endtask

    task automatic test_mid_reset();
        settle(3);
        sig1 = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (obs1 !== 6'b000101) begin
            failures++; $display("FAIL midreset_pulse: got %b expected %b", obs1, 6'b000101);
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if (obs1 !== 6'b0) begin
            failures++; $display("FAIL midreset_drop: got %b expected %b", obs1, 6'b0);
        end
        sig1 = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            #2;
            checks++;
            if (obs1 !== 6'b0) begin
                failures++; $display("FAIL midreset_release[%0d]: got %b expected %b", k, obs1, 6'b0);
            end
        end
    endtask

    task automatic test_sync4();
        logic [23:0] exp_seq [5] = '{24'h000000, 24'h000000, 24'h505000, 24'h000505, 24'h000000};
        settle(5);
        sig4 = 4'b0101;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            #2;
            checks++;
            if (obs4 !== exp_seq[k]) begin
                failures++; $display("FAIL sync4[%0d]: got %h expected %h", k, obs4, exp_seq[k]);
            end
        end
    endtask

    task automatic test_random();
        logic [5:0]  e1;
        logic [23:0] e4;
        settle(4);
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            reset = 1'b1;
            sig1  = 1'($urandom);
            sig4  = 4'($urandom);
            #2;
            e1 = model1();
            e4 = model4();
            checks++;
            if (obs1 !== e1) begin
                failures++; $display("FAIL random1[%0d]: got %b expected %b", k, obs1, e1);
            end
            checks++;
            if (obs4 !== e4) begin
                failures++; $display("FAIL random4[%0d]: got %h expected %h", k, obs4, e4);
            end
            if ($urandom_range(0, 39) == 0) begin
                #1 reset = 1'b0;
                #1;
                e1 = model1();
                e4 = model4();
                checks++;
                if ({obs1, obs4} !== {e1, e4}) begin
                    failures++; $display("FAIL random_reset[%0d]: got %b_%h expected %b_%h", k, obs1, obs4, e1, e4);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_rising();
        test_falling();
        test_alternating();
        test_glitch();
        test_mid_reset();
        test_sync4();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
